// File: rtl/tow_input_pkg.sv
// Shared types and default parameters for the tow_input release-pulse conditioner.
package tow_input_pkg;

    typedef enum logic {
        PRESSED  = 1'b0,
        RELEASED = 1'b1
    } tow_state_e;

    localparam int unsigned TOW_SYNC_STAGES = 2;
    localparam int unsigned TOW_DEBOUNCE    = 0;

    // Debounce counter width, never below one bit.
    function automatic int unsigned tow_cnt_width(input int unsigned debounce);
        return (debounce > 0) ? $clog2(debounce + 1) : 1;
    endfunction

endpackage

// File: rtl/tow_input_sync.sv
// N-flop synchronizer with asynchronous active-high reset to a configurable level.
module tow_input_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tow_input.sv
// Key input conditioner: synchronize, optionally debounce, and emit one pulse per release.
module tow_input
    import tow_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = TOW_SYNC_STAGES,
    parameter int unsigned DEBOUNCE    = TOW_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int unsigned CNT_W = tow_cnt_width(DEBOUNCE);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("tow_input: SYNC_STAGES must be 2 or more");
    end

    logic in_sync;
    logic in_ok;

    // Reset to 1 so a low input at reset release reads as a release.
    tow_input_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (in_sync)
    );

    if (DEBOUNCE > 0) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             in_ok_q, in_ok_d;

        always_comb begin
            cnt_d   = '0;
            in_ok_d = in_ok_q;
            if (in_sync != in_ok_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                    in_ok_d = in_sync;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q   <= '0;
                in_ok_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_d;
                in_ok_q <= in_ok_d;
            end
        end

        assign in_ok = in_ok_q;
    end else begin : g_no_debounce
        assign in_ok = in_sync;
    end

    tow_state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PRESSED;
        end else begin
            state_q <= state_d;
        end
    end

    // Mealy output: the pulse appears in the same cycle in_ok falls.
    always_comb begin
        state_d = state_q;
        out     = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (in_ok) state_d = PRESSED;
            end
            PRESSED: begin
                if (!in_ok) begin
                    out     = 1'b1;
                    state_d = RELEASED;
                end
            end
            default: state_d = PRESSED;
        endcase
    end

endmodule

// File: tb/tb_tow_input.sv
// Scoreboard bench: DUT0 without debounce, DUT1 with DEBOUNCE=3; expected pulse cycles queued.
module tb_tow_input;

    localparam int unsigned D1 = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in0 = 1'b1;
    logic in1 = 1'b1;
    logic out0, out1;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tow_input #(.SYNC_STAGES(2), .DEBOUNCE(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .in    (in0),
        .out   (out0)
    );

    tow_input #(.SYNC_STAGES(2), .DEBOUNCE(D1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .in    (in1),
        .out   (out1)
    );

    // Monitors: every observed pulse must match the head of its queue.
    always @(negedge clk) begin
        if (out0 !== 1'b0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL dut0_unexpected_pulse: got out=%b at cycle %0d, required no pulse",
                         out0, cyc);
            end else begin
                int exp_c;
                exp_c = q0.pop_front();
                if (exp_c != cyc) begin
                    bad++;
                    $display("FAIL dut0_pulse_cycle: got cycle %0d, required %0d", cyc, exp_c);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out1 !== 1'b0) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL dut1_unexpected_pulse: got out=%b at cycle %0d, required no pulse",
                         out1, cyc);
            end else begin
                int exp_c;
                exp_c = q1.pop_front();
                if (exp_c != cyc) begin
                    bad++;
                    $display("FAIL dut1_pulse_cycle: got cycle %0d, required %0d", cyc, exp_c);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // All expected pulses consumed and both outputs idle.
    task automatic checkpoint(input string name);
        total++;
        if (q0.size() != 0 || q1.size() != 0 || out0 !== 1'b0 || out1 !== 1'b0) begin
            bad++;
            $display("FAIL %s: got pending=%0d/%0d out=%b/%b, required pending=0/0 out=0/0",
                     name, q0.size(), q1.size(), out0, out1);
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic expect_out0(input string name, input logic exp_v);
        total++;
        if (out0 !== exp_v) begin
            bad++;
            $display("FAIL %s: got out=%b, required %b", name, out0, exp_v);
        end
    endtask

    initial begin
        // Reset with input high, then 10 quiet cycles.
        tick(3);
        total++;
        if (out0 !== 1'b0 || out1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got %b/%b, required 0/0", out0, out1);
        end
        reset = 1'b0;
        tick(10);
        checkpoint("reset_release_quiet");

        // Single release: pulse at 2 (+3 debounce) edges after the drive point.
        in0 = 1'b0; q0.push_back(cyc + 2);
        in1 = 1'b0; q1.push_back(cyc + 2 + D1);
        tick(7);
        checkpoint("single_release");

        // Press gives nothing; release gives one pulse.
        in0 = 1'b1;
        in1 = 1'b1;
        tick(6);
        checkpoint("press_no_pulse");
        in0 = 1'b0; q0.push_back(cyc + 2);
        in1 = 1'b0; q1.push_back(cyc + 2 + D1);
        tick(8);
        checkpoint("press_release");

        // One-cycle glitches: pulse each time without debounce, never with it.
        in0 = 1'b1;
        in1 = 1'b1;
        tick(8);
        checkpoint("rearm");
        in0 = 1'b0; q0.push_back(cyc + 2);
        in1 = 1'b0;
        tick(1);
        in0 = 1'b1;
        in1 = 1'b1;
        tick(3);
        in0 = 1'b0; q0.push_back(cyc + 2);
        in1 = 1'b0;
        tick(1);
        in0 = 1'b1;
        in1 = 1'b1;
        tick(8);
        checkpoint("glitches");

        // Debounced low held for 5 cycles.
        in1 = 1'b0; q1.push_back(cyc + 2 + D1);
        tick(5);
        in1 = 1'b1;
        tick(10);
        checkpoint("debounced_hold");

        // Reset while the pulse is high.
        in0 = 1'b0;
        tick(2);
        expect_out0("pulse_before_reset", 1'b1);
        reset = 1'b1;
        #1;
        expect_out0("out_async_drop", 1'b0);
        tick(5);
        expect_out0("out_during_reset", 1'b0);
        reset = 1'b0; q0.push_back(cyc + 2);
        tick(8);
        checkpoint("post_reset_pulse");

        in0 = 1'b1;
        tick(5);
        checkpoint("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
